// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers (MULT, MULTU, DIV, DIVU).
// Define MULDIV_DIVZERO_EN to add the registered div_zero output.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
`ifdef MULDIV_DIVZERO_EN
  ,
  output logic         div_zero
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [N-1:0]  acc_hi, acc_lo, mag, a_orig;
  logic          is_div, neg_x, neg_r, divz;
  logic          done_nxt, launch, write_res;

  logic          sa, sb;
  logic [N:0]    sum, shifted;
  logic [N-1:0]  diff;
  logic          ge;
  logic [2*N-1:0] prod;
  logic [N-1:0]  res_hi, res_lo;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    launch    = 1'b0;
    write_res = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        launch    = 1'b1;
      end
      RUN: begin
        if (flush) state_nxt = IDLE;
        else if (count == CW'(1)) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        if (!flush) begin
          done_nxt  = 1'b1;
          write_res = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops run on magnitudes; the sign flags drive the FIX correction.
  always_comb begin
    sa      = ~op[0] & a[N-1];
    sb      = ~op[0] & b[N-1];
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
    shifted = {acc_hi, acc_lo[N-1]};
    ge      = (shifted >= {1'b0, mag});
    diff    = shifted[N-1:0] - mag;
    prod    = {acc_hi, acc_lo};
    res_hi  = prod[2*N-1:N];
    res_lo  = prod[N-1:0];
    if (is_div) begin
      if (divz) begin
        res_hi = a_orig;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -acc_hi : acc_hi;
        res_lo = neg_x ? -acc_lo : acc_lo;
      end
    end else if (neg_x) begin
      {res_hi, res_lo} = -prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag    <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_x  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (launch) begin
        count  <= CW'(N);
        acc_hi <= '0;
        acc_lo <= op[1] ? (sa ? -a : a) : (sb ? -b : b);
        mag    <= op[1] ? (sb ? -b : b) : (sa ? -a : a);
        a_orig <= a;
        is_div <= op[1];
        neg_x  <= sa ^ sb;
        neg_r  <= sa;
        divz   <= op[1] & (b == '0);
      end else if (state == RUN) begin
        count <= count - CW'(1);
        if (is_div) begin
          acc_hi <= ge ? diff : shifted[N-1:0];
          acc_lo <= {acc_lo[N-2:0], ge};
        end else begin
          acc_hi <= sum[N:1];
          acc_lo <= {sum[0], acc_lo[N-1:1]};
        end
      end
      if (write_res) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

`ifdef MULDIV_DIVZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_zero <= 1'b0;
    else        div_zero <= write_res & is_div & divz;
  end
`endif

endmodule
